param_updown_counter: RTL

- Parametrised synchronous up/down counter; the next generation of the lab's 4-bit ripple counter.
- Adds programmable width and modulus, direction control, count enable and parallel load.
- Adds a wrap or saturate mode, a terminal-count flag and an overflow pulse.
- All flops clock on the rising edge of clk; no ripple clocking. Intended as the counting element for later divider, timer and sequencer labs.

---
 rtl/param_updown_counter_pkg.sv | 40 ++++
 rtl/param_updown_counter_next_logic.sv | 111 +++++++++++
 rtl/param_updown_counter.sv | 67 ++++++
 3 files changed

// File: rtl/param_updown_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
// Holds the mode and direction encodings, the internal operation decode
// and the parameter range check used at elaboration time.
package counter_pkg;

   // Overflow mode encodings for the SATURATE parameter.
   localparam int CNT_WRAP = 32'd0;
   localparam int CNT_SAT  = 32'd1;

   // Direction encodings for the up input.
   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

   // Operation selected for the next clock edge, after priority resolution.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_UP   = 2'd2,
      OP_DOWN = 2'd3
   } cnt_op_e;

   // True when MODULUS is a legal count-state total for a WIDTH-bit counter.
   // Widths beyond 62 bits are rejected so that 2**WIDTH stays representable.
   function automatic bit modulus_in_range(input int unsigned width,
                                           input longint unsigned modulus);
      bit ok;
      if ((width < 32'd1) || (width > 32'd62)) begin
         ok = 1'b0;
      end else begin
         ok = (modulus >= 64'd2) && (modulus <= (64'd1 << width));
      end
      return ok;
   endfunction

   // True when SATURATE holds one of the two defined mode encodings.
   function automatic bit mode_is_valid(input int mode);
      return (mode == CNT_WRAP) || (mode == CNT_SAT);
   endfunction

endpackage

// File: rtl/param_updown_counter_next_logic.sv
// Purely combinational next-state logic for param_updown_counter.
// Resolves load > enable > hold, computes the next count one bit wider than
// the counter so that a full power-of-two modulus wraps explicitly, and
// produces the overflow flag for the next cycle and the terminal-count output.
module counter_next_logic
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] q,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] next_q,
   output logic             next_ovf,
   output logic             tc
);

   // Extended-width constants: LIMIT is one past the last legal count.
   localparam logic [WIDTH:0] ZERO_EXT  = {(WIDTH+1){1'b0}};
   localparam logic [WIDTH:0] ONE_EXT   = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0] LIMIT_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_EXT   = LIMIT_EXT - ONE_EXT;
   localparam logic           SAT_MODE  = (SATURATE == CNT_SAT);

   logic [WIDTH:0] q_ext;
   logic [WIDTH:0] d_ext;
   logic [WIDTH:0] next_ext;
   logic           at_max;
   logic           at_zero;
   cnt_op_e        op;

   assign q_ext   = {1'b0, q};
   assign d_ext   = {1'b0, d};
   assign at_max  = (q_ext == MAX_EXT);
   assign at_zero = (q_ext == ZERO_EXT);

   // Priority decode of the control inputs: load beats enable, enable beats hold.
   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = OP_LOAD;
      end else if (en) begin
         if (up == DIR_UP) begin
            op = OP_UP;
         end else begin
            op = OP_DOWN;
         end
      end else begin
         op = OP_HOLD;
      end
   end

   // Next count and overflow flag for the selected operation.
   always_comb begin
      next_ext = q_ext;
      next_ovf = 1'b0;
      case (op)
         OP_LOAD: begin
            // Out-of-range load values clamp to the top of the count range.
            if (d_ext < LIMIT_EXT) begin
               next_ext = d_ext;
            end else begin
               next_ext = MAX_EXT;
            end
         end
         OP_UP: begin
            if (at_max) begin
               next_ovf = 1'b1;
               if (SAT_MODE) begin
                  next_ext = q_ext;
               end else begin
                  next_ext = ZERO_EXT;
               end
            end else begin
               next_ext = q_ext + ONE_EXT;
            end
         end
         OP_DOWN: begin
            if (at_zero) begin
               next_ovf = 1'b1;
               if (SAT_MODE) begin
                  next_ext = q_ext;
               end else begin
                  next_ext = MAX_EXT;
               end
            end else begin
               next_ext = q_ext - ONE_EXT;
            end
         end
         OP_HOLD: begin
            next_ext = q_ext;
            next_ovf = 1'b0;
         end
         default: begin
            next_ext = q_ext;
            next_ovf = 1'b0;
         end
      endcase
   end

   // The top bit of next_ext is always clear because every path stays in range.
   assign next_q = next_ext[WIDTH-1:0];

   // Terminal count is deliberately not gated by load so cascades stay simple.
   assign tc = en & (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with load, wrap/saturate mode,
// combinational terminal count and a registered overflow pulse.
// This level owns only the state registers and the asynchronous reset;
// all next-state decisions live in counter_next_logic.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   // Reject illegal parameter combinations while elaborating.
   if (!modulus_in_range(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
      $error("param_updown_counter: MODULUS must lie in 2..2**WIDTH (WIDTH >= 1)");
   end
   if (!mode_is_valid(SATURATE)) begin : g_bad_mode
      $error("param_updown_counter: SATURATE must be 0 (wrap) or 1 (saturate)");
   end

   logic [WIDTH-1:0] q_r;
   logic             ovf_r;
   logic [WIDTH-1:0] next_q_s;
   logic             next_ovf_s;
   logic             tc_s;

   counter_next_logic #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_next (
      .q        (q_r),
      .en       (en),
      .up       (up),
      .load     (load),
      .d        (d),
      .next_q   (next_q_s),
      .next_ovf (next_ovf_s),
      .tc       (tc_s)
   );

   // Count and overflow registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r   <= {WIDTH{1'b0}};
         ovf_r <= 1'b0;
      end else begin
         q_r   <= next_q_s;
         ovf_r <= next_ovf_s;
      end
   end

   assign q   = q_r;
   assign ovf = ovf_r;
   assign tc  = tc_s;

endmodule
